// File: rtl/vfm_ipc_pkg.sv
// Shared constants for the core0 inbound message arbiter.
// Status word layout, source-ID width and handshake FSM encodings.
package vfm_ipc_pkg;

    localparam int MSG_W = 14;
    localparam int SRC_W = 2;
    localparam int CNT_W = 4;

    localparam int ST_NONEMPTY = 0;
    localparam int ST_FULL     = 1;
    localparam int ST_CNT_LSB  = 2;
    localparam int ST_SRC_LSB  = 6;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] ACKED = 1'b1;

    typedef struct packed {
        logic [SRC_W-1:0] src;
        logic [MSG_W-1:0] data;
    } mb_entry_t;

endpackage

// File: rtl/vfm_ipc_fifo.sv
// Small synchronous FIFO holding {source ID, message} entries.
// Push is dropped when full and pop is dropped when empty.
module vfm_ipc_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic [AW:0]  count,
    output logic         full,
    output logic         empty
);

    localparam logic [AW:0] CNT_MAX = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          wr;
    logic          rd;

    assign full  = (count == CNT_MAX);
    assign empty = (count == '0);
    assign wr    = push && !full;
    assign rd    = pop && !empty;
    assign dout  = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers are exactly AW bits so they wrap on their own.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr) wr_ptr <= wr_ptr + AW'(1);
            if (rd) rd_ptr <= rd_ptr + AW'(1);
            case ({wr, rd})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/vfm_ipc_arbiter.sv
// Round-robin arbiter sharing core0's inbound channel among peer cores.
// Accepted messages are queued with their source ID; core0 pops by toggle.
module vfm_ipc_arbiter
    import vfm_ipc_pkg::*;
#(
    parameter int NREQ  = 3,
    parameter int DW    = MSG_W,
    parameter int DEPTH = 4
) (
    input  logic              Clock_pin,
    input  logic              Resetn_pin,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]   req_ack,
    output logic [DW-1:0]     mb_data,
    output logic [DW-1:0]     mb_status,
    input  logic [DW-1:0]     mb_pop_word
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = DW + SRC_W;

    logic [0:0]       st [NREQ];
    logic [SRC_W-1:0] rr_ptr;
    logic [SRC_W-1:0] nxt_ptr;
    logic             pop_prev;
    logic             pop_req;
    logic [NREQ-1:0]  elig;
    logic             gnt;
    logic [SRC_W-1:0] gnt_id;
    logic [DW-1:0]    gnt_data;
    logic [EW-1:0]    head;
    logic [AW:0]      count;
    logic             full;
    logic             empty;
    logic             unused_pop_bits;

    assign unused_pop_bits = ^mb_pop_word[DW-1:1];
    assign pop_req         = mb_pop_word[0] ^ pop_prev;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            elig[i]    = req_valid[i] && (st[i] == IDLE);
            req_ack[i] = (st[i] == ACKED);
        end
    end

    // First eligible peer in rotation order starting at rr_ptr wins.
    always_comb begin
        gnt      = 1'b0;
        gnt_id   = '0;
        gnt_data = '0;
        for (int k = 0; k < NREQ; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!gnt && !full && elig[i] &&
                    ((int'(rr_ptr) + k) % NREQ == i)) begin
                    gnt      = 1'b1;
                    gnt_id   = SRC_W'(i);
                    gnt_data = req_data[i*DW +: DW];
                end
            end
        end
    end

    always_comb begin
        nxt_ptr = rr_ptr;
        if (gnt) begin
            nxt_ptr = (int'(gnt_id) + 1 == NREQ) ? '0 : gnt_id + SRC_W'(1);
        end
    end

    always_ff @(posedge Clock_pin or negedge Resetn_pin) begin
        if (!Resetn_pin) begin
            rr_ptr   <= '0;
            pop_prev <= 1'b0;
        end else begin
            rr_ptr   <= nxt_ptr;
            pop_prev <= mb_pop_word[0];
        end
    end

    // A peer stays ACKED until it drops valid, so it cannot be re-granted early.
    always_ff @(posedge Clock_pin or negedge Resetn_pin) begin
        if (!Resetn_pin) begin
            for (int i = 0; i < NREQ; i++) begin
                st[i] <= IDLE;
            end
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                case (st[i])
                    IDLE: begin
                        if (gnt && gnt_id == SRC_W'(i)) st[i] <= ACKED;
                    end
                    ACKED: begin
                        if (!req_valid[i]) st[i] <= IDLE;
                    end
                    default: st[i] <= IDLE;
                endcase
            end
        end
    end

    vfm_ipc_fifo #(
        .W     (EW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk   (Clock_pin),
        .rst_n (Resetn_pin),
        .push  (gnt),
        .pop   (pop_req),
        .din   ({gnt_id, gnt_data}),
        .dout  (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    assign mb_data = empty ? '0 : head[DW-1:0];

    always_comb begin
        mb_status                            = '0;
        mb_status[ST_NONEMPTY]               = !empty;
        mb_status[ST_FULL]                   = full;
        mb_status[ST_CNT_LSB +: CNT_W]       = CNT_W'(count);
        if (!empty) begin
            mb_status[ST_SRC_LSB +: SRC_W]   = head[EW-1 -: SRC_W];
        end
    end

endmodule

// File: doc/vfm_ipc_arbiter.md
Name: vfm_ipc_arbiter

Overview:
- Shares core0's inbound message channel among up to 4 peer cores in the multicore build.
- Arbitrates peer requests round-robin and completes a 4-phase valid/ack handshake with each peer.
- Queues each accepted 14-bit message, tagged with its source ID, in a small FIFO.
- Core0 reads the FIFO head and status through two In ports and pops entries by toggling a bit on one of its Out ports.

Parameters:
- NREQ, 3, number of requesting peer cores (1..4).
- DW, 14, message width; matches the core In/Out port width.
- DEPTH, 4, FIFO entries (power of 2, 2..8).

Ports:
- Clock_pin  in  1  system clock (pll_outClk).
- Resetn_pin  in  1  reset; asynchronous, active-low.
- req_valid  in  NREQ  per-peer request, level; held until ack is seen.
- req_data  in  NREQ*DW  per-peer message, flattened; peer i occupies bits [i*DW +: DW]; stable while req_valid is high.
- req_ack  out  NREQ  per-peer acknowledge.
- mb_data  out  DW  FIFO head message; 0 when empty.
- mb_status  out  DW  status word:
  - bit0 nonempty
  - bit1 full
  - bits[5:2] count
  - bits[7:6] head source ID
  - bits[13:8] zero
- mb_pop_word  in  DW  core0 Out word; bit0 is the pop toggle, other bits ignored.

Behaviour:
- Reset (async, Resetn_pin low):
  - req_ack=0, FIFO empty (count=0), mb_data=0, mb_status=0.
  - RR pointer=0, pop_prev=0, all per-peer FSMs in IDLE.
  - This applies mid-handshake as well: any in-flight ack is dropped and unqueued data is discarded.
- Per-peer handshake FSM, states IDLE, ACKED:
  - IDLE -> ACKED when the peer is granted. On that edge, {id, req_data[i]} is written to the FIFO and req_ack[i] is set to 1.
  - ACKED -> IDLE on the first edge where req_valid[i]=0. req_ack[i] clears on that edge.
  - A peer in ACKED is not eligible for a grant, even if req_valid stays high.
- Arbitration, evaluated every cycle:
  - Eligible = req_valid[i] & state[i]==IDLE.
  - At most one grant per cycle, and only if registered full==0.
  - Search order starts at the RR pointer. After a grant the pointer moves to (granted+1) mod NREQ.
  - If nothing is granted, the pointer is unchanged.
- Latency:
  - req_valid high at edge t (peer eligible, FIFO not full) -> req_ack high and entry visible on mb_data/mb_status after edge t+1.
  - Peer drops valid -> ack low one edge later.
- Pop:
  - pop_prev registers mb_pop_word[0] each cycle.
  - pop = mb_pop_word[0] ^ pop_prev.
  - When pop occurs and the FIFO is nonempty, advance the head and decrement count.
  - When pop occurs and the FIFO is empty, ignore it; pop_prev still updates.
- Simultaneous push and pop: both take effect, count is unchanged, and head/tail pointers each advance.
- Full:
  - No grant while count==DEPTH. Waiting peers keep valid high and stall; they are not dropped.
  - A pop at edge t clears full, so a grant is possible at edge t+1 at the earliest.
- Wrap-around: pointers are log2(DEPTH) bits and wrap naturally. count is log2(DEPTH)+1 bits, so count==DEPTH is representable.
- mb_data/mb_status are driven combinationally from registered FIFO state; no read latency beyond the FIFO registers.
- Source IDs are 0-based peer index: peer i -> ID i.

Decomposition:
- Shared package vfm_ipc_pkg contains:
  - MSG_W=14
  - status bit positions (ST_NONEMPTY=0, ST_FULL=1, ST_CNT_LSB=2, ST_SRC_LSB=6)
  - SRC_W=2
  - FSM state encodings (IDLE, ACKED)
- Sub-module vfm_ipc_fifo:
  - Synchronous FIFO of width DW+SRC_W, depth DEPTH, async active-low reset.
  - Ports: push, pop, din, dout, count, full, empty.
  - Arbiter top handles RR, per-peer FSMs, toggle detection, and status packing.

Test Plan:
- Single request: peer1 valid with data 0x1A5. Expect ack after 1 edge; mb_data=0x1A5; mb_status=0x045 (nonempty, count=1, src=1). Drop valid -> ack low next edge.
- Contention: peers 0, 1, 2 raise valid in the same cycle with 0x001, 0x002, 0x003. Expect grants on successive edges in order 0, 1, 2; count=3. Pops (toggle 0→1→0→1) return 0x001, 0x002, 0x003 with src 0, 1, 2.
- Full stall: DEPTH=4 pre-filled via 4 handshakes; peer2 requests 0x3FF. Expect ack held low and status bit1=1. One pop toggle -> ack on the following edge and count back to 4.
- Empty pop: toggle bit0 twice with an empty FIFO. Expect count stays 0, mb_data=0, no underflow. A subsequent push of 0x055 shows count=1.
- Simultaneous push/pop: count=2, pop toggle in the same cycle peer0 is granted 0x123. Expect count=2, head advanced, 0x123 at tail.
- Reset mid-op: assert Resetn_pin low between edges while req_ack[1]=1 and count=3. Expect immediate req_ack=0, mb_status=0, mb_data=0. After release with peer1 valid still high, peer1 is re-granted one edge later.
